line_addr_sequencer: RTL and testbench

// - Rebuilds bus byte addresses from cache-line fields {tag, index, offset} for line fill and writeback bursts.
// - Accepts one line request, then emits one beat address per bus handshake until the whole line is covered.
// - Sits between the cache controller miss/evict logic and the memory-side address channel.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/line_beat_counter.sv | 46 ++++
 rtl/line_addr_sequencer.sv | 129 ++++++++++++
 tb/tb_line_addr_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Brief   : Cache line geometry constants, sequencer state and line address
//           layout shared by the line address sequencer.
// Revision: 1.0
// ============================================================================
package cache_pkg;

    localparam int C_ADDR_WIDTH  = 32;
    localparam int C_TAG_BITS    = 22;
    localparam int C_INDEX_BITS  = 4;
    localparam int C_OFFSET_BITS = 6;
    localparam int C_BEAT_BITS   = 2;
    localparam int C_BEATS       = 2 ** (C_OFFSET_BITS - C_BEAT_BITS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [C_TAG_BITS-1:0]    tag;
        logic [C_INDEX_BITS-1:0]  index;
        logic [C_OFFSET_BITS-1:0] offset;
    } line_addr_t;

endpackage
`default_nettype wire

// File: rtl/line_beat_counter.sv
`default_nettype none
// ============================================================================
// Module  : line_beat_counter
// Brief   : Loadable wrapping beat counter with a remaining-beats count and
//           last-beat detect for one cache line burst.
// Revision: 1.0
// ============================================================================
module line_beat_counter
    import cache_pkg::*;
#(
    parameter int BEAT_CNT_BITS = C_OFFSET_BITS - C_BEAT_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [BEAT_CNT_BITS-1:0] start_beat,
    input  logic                     advance,
    output logic [BEAT_CNT_BITS-1:0] beat,
    output logic                     last
);

    localparam int C_NUM_BEATS = 2 ** BEAT_CNT_BITS;
    localparam int C_REM_BITS  = $clog2(C_NUM_BEATS + 1);

    logic [BEAT_CNT_BITS-1:0] r_beat;
    logic [C_REM_BITS-1:0]    r_remaining;

    // The beat index wraps naturally at its width, giving the critical-word wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat      <= '0;
            r_remaining <= '0;
        end else if (load) begin
            r_beat      <= start_beat;
            r_remaining <= C_REM_BITS'(C_NUM_BEATS);
        end else if (advance) begin
            r_beat      <= r_beat + BEAT_CNT_BITS'(1);
            r_remaining <= r_remaining - C_REM_BITS'(1);
        end
    end

    assign beat = r_beat;
    assign last = (r_remaining == C_REM_BITS'(1));

endmodule
`default_nettype wire

// File: rtl/line_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : line_addr_sequencer
// Brief   : Turns one {tag, index, offset} line request into a burst of bus
//           beat addresses. Define CRIT_WORD_FIRST_EN to start at the
//           requested beat and wrap; otherwise bursts always start at beat 0.
// Revision: 1.0
// ============================================================================
module line_addr_sequencer
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = C_ADDR_WIDTH,
    parameter int OFFSET_BITS = C_OFFSET_BITS,
    parameter int INDEX_BITS  = C_INDEX_BITS,
    parameter int TAG_BITS    = C_TAG_BITS,
    parameter int BEAT_BITS   = C_BEAT_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [TAG_BITS-1:0]    req_tag,
    input  logic [INDEX_BITS-1:0]  req_index,
    input  logic [OFFSET_BITS-1:0] req_offset,
    input  logic                   req_write,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic                   bus_write,
    output logic                   bus_last,
    output logic                   done
);

    localparam int C_BEAT_CNT_BITS = OFFSET_BITS - BEAT_BITS;

    if ((ADDR_WIDTH != TAG_BITS + INDEX_BITS + OFFSET_BITS) ||
        (ADDR_WIDTH != $bits(line_addr_t))) begin : g_bad_cfg
        $error("line_addr_sequencer: ADDR_WIDTH must equal TAG_BITS+INDEX_BITS+OFFSET_BITS");
    end

    seq_state_e                 r_state;
    logic [TAG_BITS-1:0]        r_tag;
    logic [INDEX_BITS-1:0]      r_index;
    logic                       r_write;
    logic                       r_bus_valid;
    logic                       r_done;

    logic                       w_accept;
    logic                       w_handshake;
    logic                       w_last;
    logic [C_BEAT_CNT_BITS-1:0] w_start_beat;
    logic [C_BEAT_CNT_BITS-1:0] w_beat;
    line_addr_t                 w_beat_line;
    logic                       w_unused_offset;

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_handshake = r_bus_valid && bus_ready;

`ifdef CRIT_WORD_FIRST_EN
    assign w_start_beat = req_offset[OFFSET_BITS-1:BEAT_BITS];
`else
    assign w_start_beat = '0;
`endif
    // Sub-beat offset bits never affect the burst.
    assign w_unused_offset = ^req_offset;

    line_beat_counter #(
        .BEAT_CNT_BITS (C_BEAT_CNT_BITS)
    ) u_beat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_accept),
        .start_beat (w_start_beat),
        .advance    (w_handshake),
        .beat       (w_beat),
        .last       (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tag       <= '0;
            r_index     <= '0;
            r_write     <= 1'b0;
            r_bus_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state     <= BURST;
                        r_tag       <= req_tag;
                        r_index     <= req_index;
                        r_write     <= req_write;
                        r_bus_valid <= 1'b1;
                    end
                end
                BURST: begin
                    if (w_handshake && w_last) begin
                        r_state     <= IDLE;
                        r_bus_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_bus_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_beat_line        = '0;
        w_beat_line.tag    = r_tag;
        w_beat_line.index  = r_index;
        w_beat_line.offset = {w_beat, {BEAT_BITS{1'b0}}};
    end

    assign req_ready = (r_state == IDLE);
    assign bus_valid = r_bus_valid;
    assign bus_addr  = w_beat_line;
    assign bus_write = r_write;
    assign bus_last  = r_bus_valid && w_last;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_line_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_line_addr_sequencer
// Brief   : Directed, table-driven self-checking bench for line_addr_sequencer.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_line_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [21:0] req_tag = '0;
    logic [3:0]  req_index = '0;
    logic [5:0]  req_offset = '0;
    logic        req_write = 1'b0;
    logic        bus_valid;
    logic        bus_ready = 1'b1;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic        bus_last;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [21:0] tag;
        logic [3:0]  idx;
        logic [5:0]  off;
        logic        wr;
        logic [31:0] base;
        int          crit_start;
        int          stall_beat;
        int          stall_len;
    } req_vec_t;

    req_vec_t tbl [3];

    line_addr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_index  (req_index),
        .req_offset (req_offset),
        .req_write  (req_write),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_write  (bus_write),
        .bus_last   (bus_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int start_of(input int crit);
`ifdef CRIT_WORD_FIRST_EN
        return crit;
`else
        return 0;
`endif
    endfunction

    // Presents a request for one accept cycle, then scrambles the req_* inputs.
    task automatic issue(input req_vec_t r);
        check("idle_req_ready", req_ready, 1);
        req_tag    = r.tag;
        req_index  = r.idx;
        req_offset = r.off;
        req_write  = r.wr;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        req_tag    = 22'h2AAAAA;
        req_index  = 4'h3;
        req_offset = 6'h15;
        req_write  = ~r.wr;
    endtask

    // Checks nbeats beats starting at the current negedge; optionally the done cycle.
    task automatic run_beats(input logic [31:0] base, input int start, input logic wr,
                             input int nbeats, input int stall_beat, input int stall_len,
                             input bit expect_done);
        for (int k = 0; k < nbeats; k++) begin
            logic [31:0] ea;
            ea = base + 32'(((start + k) % 16) * 4);
            if (k == stall_beat) begin
                bus_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", bus_valid, 1);
                    check("stall_addr", bus_addr, ea);
                    check("stall_last", bus_last, 32'(k == 15));
                    check("stall_write", bus_write, wr);
                    @(negedge clk);
                end
                bus_ready = 1'b1;
            end
            check("beat_valid", bus_valid, 1);
            check("beat_addr", bus_addr, ea);
            check("beat_last", bus_last, 32'(k == 15));
            check("beat_write", bus_write, wr);
            check("beat_done", done, 0);
            check("beat_req_ready", req_ready, 0);
            @(negedge clk);
        end
        if (expect_done) begin
            check("done_pulse", done, 1);
            check("done_req_ready", req_ready, 1);
            check("done_bus_valid", bus_valid, 0);
            check("done_bus_last", bus_last, 0);
            @(negedge clk);
            check("done_single_cycle", done, 0);
        end
    endtask

    initial begin
        tbl[0] = '{22'h3ABCDE, 4'h5, 6'h24, 1'b0, 32'hEAF37940,  9, -1, 0};
        tbl[1] = '{22'h3ABCDE, 4'h5, 6'h24, 1'b1, 32'hEAF37940,  9,  4, 3};
        tbl[2] = '{22'h000001, 4'hF, 6'h3F, 1'b0, 32'h000007C0, 15, -1, 0};

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_last", bus_last, 0);
        check("rst_bus_write", bus_write, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            issue(tbl[i]);
            run_beats(tbl[i].base, start_of(tbl[i].crit_start), tbl[i].wr, 16,
                      tbl[i].stall_beat, tbl[i].stall_len, 1'b1);
        end

        // Back-to-back: second request held on req_* throughout the first burst
        req_tag    = tbl[0].tag;
        req_index  = tbl[0].idx;
        req_offset = tbl[0].off;
        req_write  = 1'b0;
        req_valid  = 1'b1;
        @(negedge clk);
        req_tag    = 22'h155555;
        req_index  = 4'hA;
        req_offset = 6'h08;
        req_write  = 1'b1;
        run_beats(32'hEAF37940, start_of(9), 1'b0, 16, -1, 0, 1'b1);
        req_valid  = 1'b0;
        run_beats(32'h55555680, start_of(2), 1'b1, 16, -1, 0, 1'b1);

        // Asynchronous reset mid-burst after eight handshakes
        issue(tbl[0]);
        run_beats(tbl[0].base, start_of(tbl[0].crit_start), 1'b0, 8, -1, 0, 1'b0);
        check("pre_reset_valid", bus_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bus_valid", bus_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_bus_last", bus_last, 0);
        check("mid_rst_bus_addr", bus_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(tbl[2]);
        run_beats(tbl[2].base, start_of(tbl[2].crit_start), 1'b0, 16, -1, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
